// File: rtl/quad_gen.sv
// Quadrature pulse generator: emits N Gray-coded A/B cycles per command,
// tracking a wrapping 8-bit net position and supporting early abort.
module quad_gen #(
  parameter int PHASE_CYCLES = 16,
  parameter int STEP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [STEP_WIDTH-1:0] cmd_steps,
  input  logic                  cmd_abort,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic                  step_pulse,
  output logic [7:0]            position,
  output logic [1:0]            dbg_state_o
);

  // cmd handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, no queueing.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0]           PH_LAST  = 16'(PHASE_CYCLES - 1);
  localparam logic [STEP_WIDTH-1:0] ONE_STEP = STEP_WIDTH'(1);

  state_t                state_q, state_d;
  logic [1:0]            ab_q, ab_d;
  logic [15:0]           phase_cnt_q, phase_cnt_d;
  logic [1:0]            quarter_q, quarter_d;
  logic [STEP_WIDTH-1:0] remain_q, remain_d;
  logic                  dir_q, dir_d;
  logic                  abort_q, abort_d;
  logic [7:0]            pos_q, pos_d;
  logic                  pulse_q, pulse_d;

  // Quarter 3 is always 00; forward has A leading B, reverse has B leading A.
  function automatic logic [1:0] phase_ab(input logic dir, input logic [1:0] qtr);
    logic [1:0] val;
    val = 2'b00;
    case (qtr)
      2'd0: val = dir ? 2'b10 : 2'b01;
      2'd1: val = 2'b11;
      2'd2: val = dir ? 2'b01 : 2'b10;
      default: val = 2'b00;
    endcase
    return val;
  endfunction

  always_comb begin
    state_d     = state_q;
    ab_d        = ab_q;
    phase_cnt_d = phase_cnt_q;
    quarter_d   = quarter_q;
    remain_d    = remain_q;
    dir_d       = dir_q;
    abort_d     = abort_q;
    pos_d       = pos_q;
    pulse_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_d       = cmd_dir;
          remain_d    = cmd_steps;
          abort_d     = 1'b0;
          phase_cnt_d = 16'd0;
          quarter_d   = 2'd0;
          if (cmd_steps == '0) begin
            state_d = S_DONE;
            ab_d    = 2'b00;
          end else begin
            state_d = S_RUN;
            ab_d    = phase_ab(cmd_dir, 2'd0);
          end
        end
      end
      S_RUN: begin
        if (cmd_abort) abort_d = 1'b1;
        if (phase_cnt_q == PH_LAST) begin
          phase_cnt_d = 16'd0;
          if (quarter_q == 2'd3) begin
            // End of the 00 phase: the step is complete and gets counted.
            remain_d  = remain_q - ONE_STEP;
            pos_d     = dir_q ? pos_q + 8'd1 : pos_q - 8'd1;
            pulse_d   = 1'b1;
            quarter_d = 2'd0;
            if (remain_q == ONE_STEP || abort_q || cmd_abort) begin
              state_d = S_DONE;
              ab_d    = 2'b00;
            end else begin
              ab_d = phase_ab(dir_q, 2'd0);
            end
          end else begin
            quarter_d = quarter_q + 2'd1;
            ab_d      = phase_ab(dir_q, quarter_q + 2'd1);
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ab_d    = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        ab_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ab_q        <= 2'b00;
      phase_cnt_q <= 16'd0;
      quarter_q   <= 2'd0;
      remain_q    <= '0;
      dir_q       <= 1'b0;
      abort_q     <= 1'b0;
      pos_q       <= 8'd0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ab_q        <= ab_d;
      phase_cnt_q <= phase_cnt_d;
      quarter_q   <= quarter_d;
      remain_q    <= remain_d;
      dir_q       <= dir_d;
      abort_q     <= abort_d;
      pos_q       <= pos_d;
      pulse_q     <= pulse_d;
    end
  end

  assign a           = ab_q[1];
  assign b           = ab_q[0];
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign step_pulse  = pulse_q;
  assign position    = pos_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: directed and random commands checked cycle by cycle
// against an arithmetic model of the expected waveform.
module tb_quad_gen;

  localparam int P  = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_dir;
  logic [SW-1:0] cmd_steps;
  logic          cmd_abort;
  logic          a, b, busy, done, step_pulse;
  logic [7:0]    position;
  logic [1:0]    dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_pos = 8'd0;
  logic [1:0] fwd_tab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_tab [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_gen #(.PHASE_CYCLES(P), .STEP_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_abort(cmd_abort),
    .a(a), .b(b), .busy(busy), .done(done), .step_pulse(step_pulse),
    .position(position), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // One command from issue to return to IDLE. Observed vector per cycle:
  // {a,b,position,step_pulse,done,busy,cmd_ready}. abort_t>0 pulses
  // cmd_abort in that cycle after accept; hold keeps cmd_valid high.
  task automatic run_cmd(input logic dir, input int steps, input bit hold, input int abort_t);
    int n, tend, s;
    logic [7:0]  pos0, ep;
    logic [1:0]  eab;
    logic        epulse, edone, ebusy, erdy;
    logic [13:0] obs, expv;
    pos0 = model_pos;
    n = steps;
    if (abort_t > 0 && steps > 0) n = (abort_t - 1) / (4 * P) + 1;
    tend = 4 * P * n + 1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_cmd got %b exp 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = SW'(steps);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    else begin
      cmd_steps = SW'(7);
      cmd_dir   = ~dir;
    end
    for (int t = 1; t <= tend + 1; t++) begin
      if (t < tend) begin
        s      = (t - 1) / (4 * P);
        eab    = dir ? fwd_tab[((t - 1) / P) % 4] : rev_tab[((t - 1) / P) % 4];
        ep     = dir ? 8'(pos0 + s) : 8'(pos0 - s);
        epulse = ((t - 1) % (4 * P) == 0) && (t > 1);
        edone  = 1'b0; ebusy = 1'b1; erdy = 1'b0;
      end else if (t == tend) begin
        eab    = 2'b00;
        ep     = dir ? 8'(pos0 + n) : 8'(pos0 - n);
        epulse = (n > 0);
        edone  = 1'b1; ebusy = 1'b1; erdy = 1'b0;
      end else begin
        eab    = 2'b00;
        ep     = dir ? 8'(pos0 + n) : 8'(pos0 - n);
        epulse = 1'b0;
        edone  = 1'b0; ebusy = 1'b0; erdy = 1'b1;
      end
      obs  = {a, b, position, step_pulse, done, busy, cmd_ready};
      expv = {eab, ep, epulse, edone, ebusy, erdy};
      checks++;
      if (obs !== expv) begin
        errors++;
        if (errors <= 40)
          $display("FAIL cycle dir=%0d steps=%0d t=%0d got %b exp %b", dir, steps, t, obs, expv);
      end
      cmd_abort = (t == abort_t);
      if (t == tend + 1) cmd_valid = 1'b0;
      @(negedge clk);
    end
    cmd_abort = 1'b0;
    model_pos = dir ? 8'(pos0 + n) : 8'(pos0 - n);
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; cmd_abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({a, b, position, step_pulse, done, busy, cmd_ready} !== {2'b00, 8'd0, 4'b0001}) begin
      errors++;
      $display("FAIL reset_state got %b exp %b",
               {a, b, position, step_pulse, done, busy, cmd_ready}, {2'b00, 8'd0, 4'b0001});
    end
    model_pos = 8'd0;
  endtask

  task automatic test_single_fwd();
    run_cmd(1'b1, 1, 1'b0, 0);
  endtask

  task automatic test_zero_steps();
    run_cmd(1'b1, 0, 1'b0, 0);
    run_cmd(1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_reverse3();
    run_cmd(1'b0, 3, 1'b0, 0);
  endtask

  task automatic test_abort();
    run_cmd(1'b1, 5, 1'b0, 4 * P + P + 5);
  endtask

  task automatic test_wrap_hold();
    run_cmd(1'b1, 255, 1'b1, 0);
  endtask

  task automatic test_mid_reset();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = SW'(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4 * P + P + 2) @(negedge clk);
    checks++;
    if ({a, b} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_phase got %b exp 11", {a, b});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a, b, position, step_pulse, done, busy} !== {2'b00, 8'd0, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset got %b exp %b",
               {a, b, position, step_pulse, done, busy}, {2'b00, 8'd0, 3'b000});
    end
    reset = 1'b0;
    model_pos = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({a, b, done, busy, cmd_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL after_reset i=%0d got %b exp 00001", i, {a, b, done, busy, cmd_ready});
      end
    end
  endtask

  task automatic test_random();
    int steps, abort_t;
    logic dir;
    for (int i = 0; i < 8; i++) begin
      dir   = 1'($urandom_range(0, 1));
      steps = $urandom_range(0, 4);
      abort_t = 0;
      if (steps > 0 && $urandom_range(0, 1) == 1) abort_t = $urandom_range(1, 4 * P * steps);
      run_cmd(dir, steps, 1'($urandom_range(0, 1)), abort_t);
    end
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_wrap_hold();
    test_zero_steps();
    test_reverse3();
    test_mid_reset();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
